// File: rtl/kisc_pkg.sv
// -----------------------------------------------------------------------------
// kisc_pkg
// Shared types and constants for the instruction-prefetch path.
//   fetch_state_t : APB read-master states (IDLE / SETUP / ACCESS)
//   fetch_entry_t : one queue entry {data, addr, err}
//   word_incr()   : byte increment between consecutive instruction words
// Entry fields are sized for the widest configuration the prefetch unit is
// built with; narrower instances zero-extend into them.
// -----------------------------------------------------------------------------
package kisc_pkg;

    localparam int KISC_MAX_ADDR_WIDTH = 32;
    localparam int KISC_MAX_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [KISC_MAX_DATA_WIDTH-1:0] data;
        logic [KISC_MAX_ADDR_WIDTH-1:0] addr;
        logic                           err;
    } fetch_entry_t;

    // Byte distance between sequential instruction words.
    function automatic int word_incr(input int data_width);
        return data_width / 8;
    endfunction

    localparam int KISC_WORD_INCR = word_incr(KISC_MAX_DATA_WIDTH);

endpackage : kisc_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding prefetched instruction entries.
// Flush has priority over push and pop. DEPTH must be a power of two so the
// read/write pointers wrap naturally.
// Ports:
//   clk        : clock
//   rst        : synchronous reset, active-high
//   flush      : empty the queue on the next edge
//   push       : write push_entry at the tail (ignored when full)
//   push_entry : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (registered storage, no input bypass)
//   count      : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import kisc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != FULL_COUNT);
    assign do_pop  = pop && (count_q != '0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // NOTE: storage is reset only because the head word is visible on the
    // core interface and must read as zero out of reset; the array is small.
    // A flush leaves the contents alone since the pointers already hide them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule : fetch_fifo

// File: rtl/apb_prefetch_unit.sv
// -----------------------------------------------------------------------------
// apb_prefetch_unit
// Instruction-prefetch engine: an APB read master that fetches sequential
// words ahead of the core into a DEPTH-entry queue. A redirect flushes the
// queue and restarts fetching; a transfer already on the bus runs to
// completion and its word is discarded.
//
// Optional feature (macro PREFETCH_ZERO_HALT_EN): a fetched all-zero word
// stops further fetching; `halted` rises once that word has been consumed,
// and a redirect resumes fetching. Without the macro, zero words are ordinary
// data and `halted` is tied low.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH (multiple of 8), DEPTH (power of two,
// >= 2), RESET_ADDR. Widths must not exceed the kisc_pkg entry field widths.
//
// Ports:
//   APB_PCLK, APB_PRESET          : clock, synchronous active-high reset
//   APB_paddr/psel/penable        : read request (address held through SETUP/ACCESS)
//   APB_pwrite, APB_pstb          : constant read, all strobes
//   APB_prdata/pready/perr        : slave response
//   redirect_valid, redirect_addr : flush and restart at a word-aligned address
//   out_valid/out_ready           : head-of-queue handshake to the core
//   out_data/out_addr/out_err     : head entry (from queue registers only)
//   halted                        : fetching stopped on a zero word
// -----------------------------------------------------------------------------
module apb_prefetch_unit
    import kisc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                    APB_PCLK,
    input  logic                    APB_PRESET,
    output logic [ADDR_WIDTH-1:0]   APB_paddr,
    output logic                    APB_psel,
    output logic                    APB_penable,
    output logic                    APB_pwrite,
    output logic [DATA_WIDTH/8-1:0] APB_pstb,
    input  logic [DATA_WIDTH-1:0]   APB_prdata,
    input  logic                    APB_pready,
    input  logic                    APB_perr,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_addr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_err,
    output logic                    halted
);

    localparam int                    PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]        DEPTH_C    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]        CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INCR  = ADDR_WIDTH'(word_incr(DATA_WIDTH));

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q;   // address of the next transfer to issue
    logic [ADDR_WIDTH-1:0] paddr_q;        // address of the transfer on the bus
    logic                  discard_q;      // in-flight word belongs to a stale stream

    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  complete;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  can_issue;
    logic                  stopped_after;
    logic [PTR_W:0]        fifo_count;
    logic [PTR_W:0]        count_after;
    fetch_entry_t          push_entry;
    fetch_entry_t          head;

    assign redirect_aligned = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    // A redirect in the same cycle as an issue takes effect immediately.
    assign issue_addr = redirect_valid ? redirect_aligned : fetch_addr_q;

    assign complete = (state_q == ACCESS) && APB_pready;
    // A redirect in the completing cycle also makes the returned word stale.
    assign push     = complete && !discard_q && !redirect_valid;
    // The queue is being flushed on a redirect, so a concurrent pop is moot.
    assign pop      = out_valid && out_ready && !redirect_valid;

    // Occupancy after this edge; decides whether another transfer may start.
    always_comb begin
        count_after = fifo_count;
        if (redirect_valid) begin
            count_after = '0;
        end else if (push && !pop) begin
            count_after = fifo_count + CNT_ONE;
        end else if (pop && !push) begin
            count_after = fifo_count - CNT_ONE;
        end
    end

    assign can_issue = (count_after < DEPTH_C) && !stopped_after;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge APB_PCLK) begin
        if (APB_PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        APB_psel    = 1'b0;
        APB_penable = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = SETUP;
                    issue   = 1'b1;
                end
            end
            SETUP: begin
                APB_psel = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                APB_psel    = 1'b1;
                APB_penable = 1'b1;
                if (APB_pready) begin
                    if (can_issue) begin
                        state_d = SETUP;
                        issue   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge APB_PCLK) begin
        if (APB_PRESET) begin
            paddr_q      <= '0;
            fetch_addr_q <= RESET_ADDR;
            discard_q    <= 1'b0;
        end else begin
            if (issue) begin
                paddr_q      <= issue_addr;
                fetch_addr_q <= issue_addr + ADDR_INCR;
            end else if (redirect_valid) begin
                fetch_addr_q <= redirect_aligned;
            end

            // APB has no abort: mark the in-flight word stale instead.
            if (complete) begin
                discard_q <= 1'b0;
            end else if (redirect_valid && (state_q != IDLE)) begin
                discard_q <= 1'b1;
            end
        end
    end

`ifdef PREFETCH_ZERO_HALT_EN
    logic stopped_q;
    logic halted_q;
    logic zero_push;

    assign zero_push     = push && (APB_prdata == '0);
    assign stopped_after = !redirect_valid && (stopped_q || zero_push);

    // The zero word is always the newest entry, so popping it is popping the
    // last entry while stopped.
    always_ff @(posedge APB_PCLK) begin
        if (APB_PRESET || redirect_valid) begin
            stopped_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            if (zero_push) begin
                stopped_q <= 1'b1;
            end
            if (stopped_q && pop && (fifo_count == CNT_ONE)) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign halted = halted_q;
`else
    assign stopped_after = 1'b0;
    assign halted        = 1'b0;
`endif

    // ------------------------------------------------------------- queue
    always_comb begin
        push_entry      = '0;
        push_entry.data = KISC_MAX_DATA_WIDTH'(APB_prdata);
        push_entry.addr = KISC_MAX_ADDR_WIDTH'(paddr_q);
        push_entry.err  = APB_perr;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk        (APB_PCLK),
        .rst        (APB_PRESET),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign out_valid   = (fifo_count != '0);
    assign out_data    = head.data[DATA_WIDTH-1:0];
    assign out_addr    = head.addr[ADDR_WIDTH-1:0];
    assign out_err     = head.err;

    assign APB_paddr   = paddr_q;
    assign APB_pwrite  = 1'b0;
    assign APB_pstb    = '1;

endmodule : apb_prefetch_unit
